// File: rtl/rv32_regfile_pkg.sv
// rv32_regfile_pkg: shared widths, sweep states and flat {hart, reg} indexing for the multi-hart regfile
`ifndef XPR_LEN
`define XPR_LEN 32
`endif
package rv32_regfile_pkg;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REGS_PER_HART = 32;
  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_HART} regfile_state_e;
  function automatic int flat_idx(input int hart, input int r);
    return hart * REGS_PER_HART + r;
  endfunction
endpackage

// File: rtl/rv32_regfile_clr_seq.sv
// rv32_regfile_clr_seq: post-reset full sweep and per-hart clear FSM (clk, rst_n, clr_req/clr_hart in; ack/busy/done/ready and sweep write qualifiers out)
module rv32_regfile_clr_seq
  import rv32_regfile_pkg::*;
#(
  parameter int NUM_HARTS = 8,
  parameter int HART_W = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr_req,
  input  logic [HART_W-1:0]         clr_hart,
  output logic                      clr_ack,
  output logic                      clr_busy,
  output logic                      clr_done,
  output logic                      ready,
  output logic                      all_clr,
  output logic                      hart_clr,
  output logic [HART_W-1:0]         cur_hart,
  output logic                      sw_en,
  output logic [HART_W-1:0]         sw_hart,
  output logic [REG_ADDR_WIDTH-1:0] sw_reg
);
  localparam int CW = $clog2(NUM_HARTS * REGS_PER_HART);
  localparam logic [CW-1:0] LAST = CW'(NUM_HARTS * REGS_PER_HART - 1);
  regfile_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HART_W-1:0] hart_q, hart_d;
  logic ack_q, ack_d, done_q, done_d, ready_q, ready_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hart_d = hart_q;
    ack_d = 1'b0;
    done_d = 1'b0;
    ready_d = ready_q;
    case (state_q)
      CLR_ALL: begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        state_d = (cnt_q == LAST) ? IDLE : CLR_ALL;
        ready_d = ready_q | (cnt_q == LAST);
      end
      IDLE: if (clr_req) begin
        state_d = CLR_HART;
        cnt_d = '0;
        hart_d = clr_hart;
        ack_d = 1'b1;
      end
      CLR_HART: begin
        cnt_d = (cnt_q[4:0] == 5'd31) ? '0 : cnt_q + CW'(1);
        state_d = (cnt_q[4:0] == 5'd31) ? IDLE : CLR_HART;
        done_d = (cnt_q[4:0] == 5'd31);
      end
      default: state_d = CLR_ALL;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_ALL;
      cnt_q <= '0;
      hart_q <= '0;
      ack_q <= 1'b0;
      done_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hart_q <= hart_d;
      ack_q <= ack_d;
      done_q <= done_d;
      ready_q <= ready_d;
    end
  end
  assign all_clr = (state_q == CLR_ALL);
  assign hart_clr = (state_q == CLR_HART);
  assign clr_busy = hart_clr;
  assign clr_ack = ack_q;
  assign clr_done = done_q;
  assign ready = ready_q;
  assign cur_hart = hart_q;
  // an illegal latched hart is still swept in time, but nothing is written
  assign sw_en = all_clr || (hart_clr && int'(hart_q) < NUM_HARTS);
  assign sw_hart = all_clr ? HART_W'(cnt_q >> REG_ADDR_WIDTH) : hart_q;
  assign sw_reg = cnt_q[REG_ADDR_WIDTH-1:0];
endmodule

// File: rtl/rv32_regfile_mh.sv
// rv32_regfile_mh: NUM_HARTS x 32 regfile, 2 comb read ports, 1 sync write port, clear sequencer; REGFILE_BYPASS_EN forwards same-cycle writes to reads
module rv32_regfile_mh
  import rv32_regfile_pkg::*;
#(
  parameter int NUM_HARTS = 8,
  parameter int XLEN = `XPR_LEN,
  localparam int HART_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [HART_W-1:0]         rd_hart1,
  input  logic [REG_ADDR_WIDTH-1:0] ra1,
  output logic [XLEN-1:0]           rd1,
  input  logic [HART_W-1:0]         rd_hart2,
  input  logic [REG_ADDR_WIDTH-1:0] ra2,
  output logic [XLEN-1:0]           rd2,
  input  logic                      wen,
  input  logic [HART_W-1:0]         wr_hart,
  input  logic [REG_ADDR_WIDTH-1:0] wa,
  input  logic [XLEN-1:0]           wd,
  input  logic                      clr_req,
  input  logic [HART_W-1:0]         clr_hart,
  output logic                      clr_ack,
  output logic                      clr_busy,
  output logic                      clr_done,
  output logic                      ready
);
  localparam int DEPTH = NUM_HARTS * REGS_PER_HART;
  localparam int IW = $clog2(DEPTH);
  logic [XLEN-1:0] mem_q [DEPTH];
  logic all_clr, hart_clr, sw_en, port_we, byp1, byp2, zero1, zero2;
  logic [HART_W-1:0] cur_hart, sw_hart;
  logic [REG_ADDR_WIDTH-1:0] sw_reg;
  logic [IW-1:0] s_idx, w_idx, r1_idx, r2_idx;
  rv32_regfile_clr_seq #(.NUM_HARTS(NUM_HARTS), .HART_W(HART_W)) u_seq (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_hart(clr_hart),
    .clr_ack(clr_ack), .clr_busy(clr_busy), .clr_done(clr_done), .ready(ready),
    .all_clr(all_clr), .hart_clr(hart_clr), .cur_hart(cur_hart),
    .sw_en(sw_en), .sw_hart(sw_hart), .sw_reg(sw_reg)
  );
  always_comb begin
    s_idx = IW'(flat_idx(int'(sw_hart), int'(sw_reg)));
    w_idx = IW'(flat_idx(int'(wr_hart), int'(wa)));
    r1_idx = IW'(flat_idx(int'(rd_hart1), int'(ra1)));
    r2_idx = IW'(flat_idx(int'(rd_hart2), int'(ra2)));
    // a hart under any sweep neither accepts writes nor shows stored data
    port_we = wen && wa != '0 && int'(wr_hart) < NUM_HARTS && !all_clr && !(hart_clr && wr_hart == cur_hart);
    zero1 = ra1 == '0 || int'(rd_hart1) >= NUM_HARTS || all_clr || (hart_clr && rd_hart1 == cur_hart);
    zero2 = ra2 == '0 || int'(rd_hart2) >= NUM_HARTS || all_clr || (hart_clr && rd_hart2 == cur_hart);
`ifdef REGFILE_BYPASS_EN
    byp1 = port_we && rd_hart1 == wr_hart && ra1 == wa;
    byp2 = port_we && rd_hart2 == wr_hart && ra2 == wa;
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
    rd1 = zero1 ? '0 : byp1 ? wd : mem_q[r1_idx];
    rd2 = zero2 ? '0 : byp2 ? wd : mem_q[r2_idx];
  end
  always_ff @(posedge clk) begin
    if (sw_en) mem_q[s_idx] <= '0;
    if (port_we) mem_q[w_idx] <= wd;
  end
endmodule

// File: tb/tb_rv32_regfile_mh.sv
// tb_rv32_regfile_mh: scoreboard bench for rv32_regfile_mh covering sweep, writes, per-hart clear, bypass and reset
module tb_rv32_regfile_mh;
  logic clk, rst_n, wen, clr_req, clr_ack, clr_busy, clr_done, ready;
  logic [2:0] rd_hart1, rd_hart2, wr_hart, clr_hart;
  logic [4:0] ra1, ra2, wa;
  logic [31:0] rd1, rd2, wd;
  logic [31:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  int bc, dc, ac;
  rv32_regfile_mh dut (
    .clk(clk), .rst_n(rst_n),
    .rd_hart1(rd_hart1), .ra1(ra1), .rd1(rd1),
    .rd_hart2(rd_hart2), .ra2(ra2), .rd2(rd2),
    .wen(wen), .wr_hart(wr_hart), .wa(wa), .wd(wd),
    .clr_req(clr_req), .clr_hart(clr_hart),
    .clr_ack(clr_ack), .clr_busy(clr_busy), .clr_done(clr_done), .ready(ready)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic rd_chk(input string tag, input int h, input int a, input logic [31:0] e);
    rd_hart1 = 3'(h);
    ra1 = 5'(a);
    rd_hart2 = 3'(h);
    ra2 = 5'(a);
    exp_q.push_back(e);
    exp_q.push_back(e);
    #1;
    chk({tag, "_p1"}, rd1, exp_q.pop_front());
    chk({tag, "_p2"}, rd2, exp_q.pop_front());
  endtask
  task automatic wr(input int h, input int a, input logic [31:0] d);
    @(posedge clk);
    #1;
    wen = 1;
    wr_hart = 3'(h);
    wa = 5'(a);
    wd = d;
    @(posedge clk);
    #1;
    wen = 0;
  endtask
  task automatic wait_ready(input string tag);
    int cyc = 0;
    while (!ready && cyc < 2000) begin
      wen = 1;
      wr_hart = 3'(cyc % 8);
      wa = 5'(cyc % 31 + 1);
      wd = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      cyc++;
    end
    wen = 0;
    chk(tag, 32'(cyc), 32'd256);
  endtask
  task automatic chk_rst(input string tag);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_ack"}, 32'(clr_ack), 0);
    chk({tag, "_busy"}, 32'(clr_busy), 0);
    chk({tag, "_done"}, 32'(clr_done), 0);
  endtask
  initial begin
    rst_n = 0; wen = 0; wr_hart = 0; wa = 0; wd = 0; clr_req = 0; clr_hart = 0;
    rd_hart1 = 0; ra1 = 0; rd_hart2 = 0; ra2 = 0;
    #3;
    chk_rst("rst0");
    @(posedge clk);
    #1;
    rst_n = 1;
    wait_ready("sweep0_cycles");
    for (int h = 0; h < 8; h++)
      for (int r = 0; r < 32; r++) rd_chk("init_zero", h, r, 0);
    wr(3, 0, 32'h1234);
    rd_chk("x0_write", 3, 0, 0);
    wr(3, 5, 32'hA5A5A5A5);
    rd_chk("h3r5", 3, 5, 32'hA5A5A5A5);
    rd_chk("h2r5", 2, 5, 0);
    wr(4, 9, 32'h11);
    @(posedge clk);
    #1;
    wen = 1; wr_hart = 4; wa = 9; wd = 32'h55;
`ifdef REGFILE_BYPASS_EN
    rd_chk("byp_same", 4, 9, 32'h55);
`else
    rd_chk("byp_same", 4, 9, 32'h11);
`endif
    @(posedge clk);
    #1;
    wen = 0;
    rd_chk("byp_next", 4, 9, 32'h55);
    for (int k = 1; k < 32; k++) begin
      wr(1, k, k);
      wr(2, k, k);
    end
    @(posedge clk);
    #1;
    clr_req = 1; clr_hart = 1;
    @(posedge clk);
    #1;
    chk("clr_ack", 32'(clr_ack), 1);
    clr_req = 0;
    bc = 0; dc = 0; ac = 0;
    for (int i = 0; i < 100 && clr_busy; i++) begin
      bc++;
      dc += int'(clr_done);
      if (i > 0) ac += int'(clr_ack);
      wen = (i == 10) || (i == 11);
      wr_hart = (i == 10) ? 3'd1 : 3'd2;
      wa = 7;
      wd = 32'h77;
      rd_chk("clr_h1_zero", 1, i % 32, 0);
      rd_chk("clr_h2_keep", 2, 3, 3);
      @(posedge clk);
      #1;
      wen = 0;
    end
    chk("clr_busy_cycles", 32'(bc), 32);
    chk("clr_early_done", 32'(dc), 0);
    chk("clr_extra_ack", 32'(ac), 0);
    chk("clr_done", 32'(clr_done), 1);
    @(posedge clk);
    #1;
    chk("clr_done_pulse", 32'(clr_done), 0);
    rd_chk("h1r7_lost", 1, 7, 0);
    rd_chk("h1r31", 1, 31, 0);
    rd_chk("h2r7_landed", 2, 7, 32'h77);
    rd_chk("h2r31", 2, 31, 31);
    @(posedge clk);
    #1;
    clr_req = 1; clr_hart = 2;
    @(posedge clk);
    #1;
    chk("held_ack1", 32'(clr_ack), 1);
    ac = 0;
    for (int i = 0; i < 100 && clr_busy; i++) begin
      @(posedge clk);
      #1;
      ac += int'(clr_ack);
    end
    chk("held_no_ack_busy", 32'(ac), 0);
    chk("held_done", 32'(clr_done), 1);
    @(posedge clk);
    #1;
    chk("held_ack2", 32'(clr_ack), 1);
    chk("held_busy2", 32'(clr_busy), 1);
    clr_req = 0;
    for (int i = 0; i < 100 && clr_busy; i++) begin
      @(posedge clk);
      #1;
    end
    chk("held_busy_end", 32'(clr_busy), 0);
    @(posedge clk);
    #1;
    chk("held_no_ack3", 32'(clr_ack), 0);
    rd_chk("h2_cleared", 2, 31, 0);
    rd_chk("h4_untouched", 4, 9, 32'h55);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    rst_n = 1;
    repeat (100) @(posedge clk);
    #1;
    chk("mid_sweep_ready", 32'(ready), 0);
    rst_n = 0;
    #1;
    chk_rst("rst_sweep");
    #2;
    rst_n = 1;
    wait_ready("sweep_restart_cycles");
    rd_chk("post_sweep_h4r9", 4, 9, 0);
    rd_chk("post_sweep_h3r5", 3, 5, 0);
    wr(5, 3, 32'h99);
    rd_chk("h5r3", 5, 3, 32'h99);
    @(posedge clk);
    #1;
    clr_req = 1; clr_hart = 5;
    @(posedge clk);
    #1;
    clr_req = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_clr_busy", 32'(clr_busy), 1);
    rst_n = 0;
    #1;
    chk_rst("rst_clr");
    #2;
    rst_n = 1;
    wait_ready("sweep_after_clr_cycles");
    rd_chk("post_clr_h5r3", 5, 3, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rv32_regfile_mh.md
Name: rv32_regfile_mh

Overview:
Multi-hart RV32 integer register file, the parametrised successor of the single-context 32x32 regfile.
- Holds NUM_HARTS banks of 32 registers, each XLEN bits, for the barrel-scheduled pito core.
- Two combinational read ports and one synchronous write port, each tagged with a hart ID.
- A clear sequencer zeroes all banks after reset. It also zeroes a single hart's bank on request, so a hart can be restarted without resetting the core.

Parameters:
NUM_HARTS, 8, number of register banks (>=1)
XLEN, 32, register width in bits
HART_W, (NUM_HARTS>1 ? $clog2(NUM_HARTS) : 1), hart-ID width (derived; not overridden)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
rd_hart1  in  HART_W  read port 1 hart select
ra1  in  5  read port 1 register address
rd1  out  XLEN  read port 1 data
rd_hart2  in  HART_W  read port 2 hart select
ra2  in  5  read port 2 register address
rd2  out  XLEN  read port 2 data
wen  in  1  write enable
wr_hart  in  HART_W  write hart select
wa  in  5  write register address
wd  in  XLEN  write data
clr_req  in  1  per-hart clear request (held until clr_ack)
clr_hart  in  HART_W  hart to clear
clr_ack  out  1  one-cycle pulse: clear request accepted
clr_busy  out  1  a per-hart clear is in progress
clr_done  out  1  one-cycle pulse: per-hart clear finished
ready  out  1  initial post-reset sweep complete

Behaviour:
- Storage: NUM_HARTS*32 entries, indexed by {hart, reg}. Hart IDs >= NUM_HARTS are illegal; reads return 0 and writes are dropped.
- Reads:
  - Combinational, zero latency.
  - rdN = 0 when raN==0.
  - rdN = 0 when the addressed hart is being cleared (CLR_ALL: every hart; CLR_HART: the selected hart).
  - Otherwise rdN is the stored value.
- Writes:
  - Commit at posedge clk when wen && wa!=0 && hart legal && hart not being cleared.
  - A write to x0 is always discarded.
- FSM states: CLR_ALL, IDLE, CLR_HART. A single counter holds the sweep address.
- Reset (any time, including mid-sweep): state=CLR_ALL, counter=0, ready=0, clr_ack=0, clr_busy=0, clr_done=0.
- CLR_ALL:
  - Writes 0 to entry[counter] each cycle; counter increments by 1.
  - After entry NUM_HARTS*32-1 is written, the next state is IDLE and ready goes to 1 on that edge.
  - Total duration is NUM_HARTS*32 cycles after rst_n deasserts.
  - All port writes are dropped; clr_req is ignored (no ack).
- IDLE with clr_req=1:
  - Latch clr_hart, pulse clr_ack for 1 cycle, go to CLR_HART, counter=0.
  - An illegal clr_hart is still acked; the sweep writes nothing.
- CLR_HART:
  - clr_busy=1.
  - Zeroes reg[counter] of the latched hart, one register per cycle, for 32 cycles.
  - Writes and reads to other harts proceed normally.
  - On the final edge: clr_busy=0, clr_done=1 for 1 cycle, return to IDLE.
  - clr_req is not acked until back in IDLE. The earliest next ack is the cycle after clr_done.
- Simultaneous events:
  - A port write to the hart being swept is dropped, even if it targets an address already swept.
  - clr_req and wen in the same IDLE cycle: the write commits normally. The write's hart becomes unreadable from the next cycle if it matches clr_hart.
- ready stays 1 until the next reset.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: a same-cycle committing write forwards combinationally onto a read port when the read's (hart, addr) matches the write's (hart, wa) and the write is legal. rdN = wd in that cycle.
- Undefined: a read in the write cycle returns the old value; the new value is visible the cycle after the edge.
- Zeroing rules (x0, harts being cleared) take precedence over bypass in both builds.

Decomposition:
- Shared package rv32_regfile_pkg:
  - REG_ADDR_WIDTH=5, REGS_PER_HART=32.
  - Enum regfile_state_e {CLR_ALL, IDLE, CLR_HART}.
  - Function that builds the flat index {hart, reg}.
- XLEN defaults from the existing XPR_LEN define.
- One natural sub-module: rv32_regfile_clr_seq. It holds the FSM, counter, ack/done/busy/ready, and outputs the sweep write enable, sweep address and hart-being-cleared qualifiers.
- The top module holds the storage array, read muxes and bypass.

Test Plan:
- Reset, NUM_HARTS=8 → ready=0 for exactly 256 cycles, then 1; every (hart, reg) reads 0. Writes of 0xDEADBEEF during the sweep are not retained.
- wen, wr_hart=3, wa=0, wd=0x1234 → ra1=0 on hart 3 reads 0. wr_hart=3, wa=5, wd=0xA5A5A5A5 → reads 0xA5A5A5A5 the next cycle on hart 3 only; hart 2 reg 5 still reads 0.
- Fill harts 1 and 2 (reg k = k), then clr_req with clr_hart=1 → clr_ack pulses next edge; clr_busy high 32 cycles; clr_done pulses once. Hart 1 reads 0 throughout and after; hart 2 keeps its values; a write to hart 1 reg 7 mid-clear is lost; a write to hart 2 reg 7 lands.
- clr_req held high during CLR_HART → exactly one additional ack, the cycle after clr_done.
- Same-cycle write hart 4 reg 9 = 0x55 with read of hart 4 reg 9 → 0x55 with REGFILE_BYPASS_EN; old value without it; 0x55 next cycle in both builds.
- Assert rst_n low at sweep index 100, and again in the middle of CLR_HART → outputs return to reset values immediately; a full 256-cycle sweep restarts from index 0.
